alu_op_sequencer: RTL

- Multi-cycle controller for the 8-bit ALU datapath: adder unit, logical unit, and the 3-input ALU output mux (OSEL 00=ADD, 01=SHIFT, 10=LOGICAL, 11=LOGICAL).
- Accepts one operation at a time over a valid/ready request port.
- Registers operands and drives the unit controls and OSEL. It owns an iterative 1-bit-per-cycle shifter feeding the mux SHIFT input.
- Captures the mux output and returns the result plus flags over a valid/ready response port.

---
 rtl/alu_seq_pkg.sv | 53 +++++
 rtl/alu_seq_shifter.sv | 62 ++++++
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, output-mux
// and logical-unit encodings, FSM states and small opcode decode helpers.
package alu_seq_pkg;

    // Request opcodes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // ALU output-mux select (11 also selects the logical unit in the mux)
    localparam logic [1:0] OSEL_ADD   = 2'b00;
    localparam logic [1:0] OSEL_SHIFT = 2'b01;
    localparam logic [1:0] OSEL_LOGIC = 2'b10;

    // Logical-unit select; equals the low two opcode bits of the logic ops
    localparam logic [1:0] LOG_AND  = 2'b00;
    localparam logic [1:0] LOG_OR   = 2'b01;
    localparam logic [1:0] LOG_XOR  = 2'b10;
    localparam logic [1:0] LOG_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SHIFT   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic [1:0] osel_for(input logic [2:0] op);
        logic [1:0] sel;
        if (is_addsub(op)) begin
            sel = OSEL_ADD;
        end else if (is_shift(op)) begin
            sel = OSEL_SHIFT;
        end else begin
            sel = OSEL_LOGIC;
        end
        return sel;
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative 1-bit-per-cycle shifter for the ALU sequencer. Holds the shift
// register, the remaining-count down-counter and the last bit shifted out.
// done is high during the shift cycle that consumes the final count.
module alu_seq_shifter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic [SHAMT_W-1:0] load_cnt,
    input  logic               shift_en,
    input  logic               shift_left,
    output logic [WIDTH-1:0]   shift_q,
    output logic               last_out,
    output logic               done
);

    logic [SHAMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0]   shl_next;
    logic [WIDTH-1:0]   shr_next;

    // Per-bit next values for both directions, zero filled at the ends
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shl_next[gi] = 1'b0;
            end else begin : g_lsb_n
                assign shl_next[gi] = shift_q[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_next[gi] = 1'b0;
            end else begin : g_msb_n
                assign shr_next[gi] = shift_q[gi+1];
            end
        end
    endgenerate

    assign done = shift_en && (cnt_reg == SHAMT_W'(1));

    // Load on request acceptance, then shift one bit per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            cnt_reg  <= '0;
            last_out <= 1'b0;
        end else if (load) begin
            shift_q  <= load_data;
            cnt_reg  <= load_cnt;
            last_out <= 1'b0;
        end else if (shift_en && (cnt_reg != '0)) begin
            shift_q  <= shift_left ? shl_next : shr_next;
            last_out <= shift_left ? shift_q[WIDTH-1] : shift_q[0];
            cnt_reg  <= cnt_reg - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the 8-bit ALU datapath. Accepts one operation
// over a valid/ready request port, drives the adder/logical-unit controls and
// the output-mux select, runs the iterative shifter for shift ops, captures
// the mux output with {N,Z,C} flags and returns it over a valid/ready port.
// Optional macro ALU_SEQ_PERF_EN adds saturating completed-op and
// result-stall counters (perf_ops, perf_stall).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]   opa,
    output logic [WIDTH-1:0]   opb,
    output logic               add_sub,
    output logic [1:0]         log_op,
    output logic [1:0]         osel,
    output logic [WIDTH-1:0]   shift_q,
    input  logic               carry_in,
    input  logic [WIDTH-1:0]   mux_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [2:0]         res_flags
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]        perf_ops,
    output logic [15:0]        perf_stall
`endif
);

    state_e             state_reg;
    state_e             state_next;
    logic [2:0]         op_reg;
    logic               shamt_nz_reg;
    logic               accept;
    logic               last_out;
    logic               shift_done;
    logic               carry_flag;
    logic [SHAMT_W-1:0] req_shamt;

    assign req_shamt = req_b[SHAMT_W-1:0];
    assign accept    = req_valid && req_ready;

    alu_seq_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_data  (req_a),
        .load_cnt   (req_shamt),
        .shift_en   (state_reg == ST_SHIFT),
        .shift_left (op_reg == OP_SHL),
        .shift_q    (shift_q),
        .last_out   (last_out),
        .done       (shift_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_shift(req_op) && (req_shamt != '0)) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operands and unit controls change only when a request is accepted;
    // add_sub and log_op are left alone by ops that do not use them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa          <= '0;
            opb          <= '0;
            add_sub      <= 1'b0;
            log_op       <= LOG_AND;
            osel         <= OSEL_ADD;
            op_reg       <= OP_ADD;
            shamt_nz_reg <= 1'b0;
        end else if (accept) begin
            opa          <= req_a;
            opb          <= req_b;
            op_reg       <= req_op;
            osel         <= osel_for(req_op);
            shamt_nz_reg <= (req_shamt != '0);
            if (is_addsub(req_op)) begin
                add_sub <= (req_op == OP_SUB);
            end
            if (osel_for(req_op) == OSEL_LOGIC) begin
                log_op <= req_op[1:0];
            end
        end
    end

    // Carry flag source depends on the operation class
    always_comb begin
        carry_flag = 1'b0;
        if (is_addsub(op_reg)) begin
            carry_flag = carry_in;
        end else if (is_shift(op_reg) && shamt_nz_reg) begin
            carry_flag = last_out;
        end
    end

    // Capture the mux result and flags; held through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data  <= '0;
            res_flags <= 3'b000;
        end else if (state_reg == ST_CAPTURE) begin
            res_data  <= mux_out;
            res_flags <= {mux_out[WIDTH-1], (mux_out == '0), carry_flag};
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops_reg;
    logic [15:0] perf_stall_reg;

    // Saturating completed-op and result back-pressure counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (res_valid && res_ready && (perf_ops_reg != 16'hFFFF)) begin
                perf_ops_reg <= perf_ops_reg + 16'd1;
            end
            if (res_valid && !res_ready && (perf_stall_reg != 16'hFFFF)) begin
                perf_stall_reg <= perf_stall_reg + 16'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_reg;
    assign perf_stall = perf_stall_reg;
`endif

endmodule
